// File: rtl/traffic_pkg.sv
// Shared types for the traffic phase controller: phase encoding and lamp triple.
package traffic_pkg;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    GREEN  = 3'd1,
    YELLOW = 3'd2,
    ALLRED = 3'd3,
    WALK   = 3'd4
  } phase_e;

  typedef struct packed {
    logic g;
    logic y;
    logic r;
  } lamp_t;

  localparam lamp_t LAMP_RED = '{g: 1'b0, y: 1'b0, r: 1'b1};
  localparam lamp_t LAMP_GRN = '{g: 1'b1, y: 1'b0, r: 1'b0};
  localparam lamp_t LAMP_YEL = '{g: 1'b0, y: 1'b1, r: 1'b0};

  // Lamp for one approach given the phase and whether that approach owns it.
  function automatic lamp_t lamp_decode(input phase_e ph, input logic owner);
    lamp_t l;
    l = LAMP_RED;
    if (owner && (ph == GREEN))  l = LAMP_GRN;
    if (owner && (ph == YELLOW)) l = LAMP_YEL;
    return l;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by TICK_DIV; tick is high for one clk on the cycle the count wraps.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  // Wrapping count 0..TICK_DIV-1.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + DIV_W'(1);
  end

  // tick is registered from the next count so it coincides with cnt_q == LAST.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= (TICK_DIV == 1);
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Round-robin actuated intersection controller with pedestrian walk phase.
// Optional macro PED_COUNTDOWN_EN adds the walk_remain countdown output.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned N_WAYS     = 2,
  parameter int unsigned CNT_W      = 3,
  parameter int unsigned TICK_DIV   = 4,
  parameter int unsigned MIN_GREEN  = 8,
  parameter int unsigned MAX_GREEN  = 20,
  parameter int unsigned YELLOW_T   = 3,
  parameter int unsigned ALLRED_T   = 1,
  parameter int unsigned WALK_T     = 6,
  parameter int unsigned EXT_THRESH = 4
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        ped_button,
  input  logic [N_WAYS*CNT_W-1:0]                     traffic_in,
  output logic [N_WAYS-1:0]                           green,
  output logic [N_WAYS-1:0]                           yellow,
  output logic [N_WAYS-1:0]                           red,
  output logic                                        walk,
  output logic                                        ped_pending,
  output logic [((N_WAYS > 1) ? $clog2(N_WAYS) : 1)-1:0] active_way
`ifdef PED_COUNTDOWN_EN
  ,
  output logic [$clog2(WALK_T+1)-1:0]                 walk_remain
`endif
);

  localparam int unsigned WAY_W   = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
  localparam int unsigned T_MAX_A = (MAX_GREEN > WALK_T) ? MAX_GREEN : WALK_T;
  localparam int unsigned T_MAX_B = (YELLOW_T > ALLRED_T) ? YELLOW_T : ALLRED_T;
  localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int unsigned TMR_W   = $clog2(T_MAX + 1);

  localparam logic [TMR_W-1:0] GMIN_END = TMR_W'(MIN_GREEN - 1);
  localparam logic [TMR_W-1:0] GMAX_END = TMR_W'(MAX_GREEN - 1);
  localparam logic [TMR_W-1:0] Y_END    = TMR_W'(YELLOW_T - 1);
  localparam logic [TMR_W-1:0] AR_END   = TMR_W'(ALLRED_T - 1);
  localparam logic [TMR_W-1:0] W_END    = TMR_W'(WALK_T - 1);
  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(N_WAYS - 1);

  logic                tick;
  phase_e              state_q, state_d;
  logic [WAY_W-1:0]    way_q, way_d, next_way_c;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                pending_q, pending_d;
  logic [1:0]          ped_sync_q;
  logic                ped_prev_q;
  logic                ped_rise_c;
  logic [CNT_W-1:0]    level_c;
  logic                extend_c;
  lamp_t               lamp_c;
  logic [N_WAYS-1:0]   green_q, green_d;
  logic [N_WAYS-1:0]   yellow_q, yellow_d;
  logic [N_WAYS-1:0]   red_q, red_d;
  logic                walk_q, walk_d;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  // Two-flop synchroniser plus a history flop for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ped_sync_q <= '0;
      ped_prev_q <= 1'b0;
    end else begin
      ped_sync_q <= {ped_sync_q[0], ped_button};
      ped_prev_q <= ped_sync_q[1];
    end
  end

  assign ped_rise_c = ped_sync_q[1] & ~ped_prev_q;

  // Traffic level of the approach currently owning the phase.
  always_comb begin
    level_c = '0;
    for (int i = 0; i < N_WAYS; i++) begin
      if (way_q == WAY_W'(i)) level_c = traffic_in[i*CNT_W +: CNT_W];
    end
  end

  assign extend_c   = (32'(level_c) >= EXT_THRESH);
  assign next_way_c = (way_q == LAST_WAY) ? '0 : way_q + WAY_W'(1);

  // Phase sequencing, phase timer and pedestrian request latch.
  always_comb begin
    state_d   = state_q;
    way_d     = way_q;
    timer_d   = timer_q;
    pending_d = pending_q;

    unique case (state_q)
      INIT: begin
        if (tick && (timer_q == AR_END)) begin
          state_d = GREEN;
          way_d   = '0;
        end
      end
      GREEN: begin
        if (tick && ((timer_q == GMAX_END) ||
                     ((timer_q >= GMIN_END) && (!extend_c || pending_q)))) begin
          state_d = YELLOW;
        end
      end
      YELLOW: begin
        if (tick && (timer_q == Y_END)) state_d = ALLRED;
      end
      ALLRED: begin
        if (tick && (timer_q == AR_END)) begin
          if (pending_q) begin
            state_d = WALK;
          end else begin
            state_d = GREEN;
            way_d   = next_way_c;
          end
        end
      end
      WALK: begin
        if (tick && (timer_q == W_END)) begin
          state_d = GREEN;
          way_d   = next_way_c;
        end
      end
      default: state_d = INIT;
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (tick) begin
      timer_d = timer_q + TMR_W'(1);
    end

    // Entering WALK serves the request; presses while walking are dropped.
    if ((state_d == WALK) && (state_q != WALK)) begin
      pending_d = 1'b0;
    end else if (ped_rise_c && (state_q != WALK)) begin
      pending_d = 1'b1;
    end
  end

  // Lamp decode from the next state so lamps switch with the state register.
  always_comb begin
    green_d  = '0;
    yellow_d = '0;
    red_d    = '0;
    lamp_c   = LAMP_RED;
    for (int i = 0; i < N_WAYS; i++) begin
      lamp_c      = lamp_decode(state_d, way_d == WAY_W'(i));
      green_d[i]  = lamp_c.g;
      yellow_d[i] = lamp_c.y;
      red_d[i]    = lamp_c.r;
    end
    walk_d = (state_d == WALK);
  end

  // State, timer, request latch and lamp registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= INIT;
      way_q     <= '0;
      timer_q   <= '0;
      pending_q <= 1'b0;
      green_q   <= '0;
      yellow_q  <= '0;
      red_q     <= '1;
      walk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      way_q     <= way_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      green_q   <= green_d;
      yellow_q  <= yellow_d;
      red_q     <= red_d;
      walk_q    <= walk_d;
    end
  end

  assign green       = green_q;
  assign yellow      = yellow_q;
  assign red         = red_q;
  assign walk        = walk_q;
  assign ped_pending = pending_q;
  assign active_way  = way_q;

`ifdef PED_COUNTDOWN_EN
  localparam int unsigned REM_W = $clog2(WALK_T + 1);

  logic [REM_W-1:0] remain_q, remain_d;

  // Remaining walk ticks, shown only while walking.
  always_comb begin
    remain_d = '0;
    if (state_d == WALK) remain_d = REM_W'(WALK_T) - REM_W'(timer_d);
  end

  // Countdown register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) remain_q <= '0;
    else          remain_q <= remain_d;
  end

  assign walk_remain = remain_q;
`endif

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: phase-segment scoreboard, vector table and corner sequences.
module tb_traffic_phase_ctrl;

  localparam int K_RED = 0;
  localparam int K_GRN = 1;
  localparam int K_YEL = 2;
  localparam int K_WLK = 3;

  logic       clk = 1'b0;
  logic       reset_n, reset3_n, ped_button;
  logic [5:0] traffic_in;
  logic [1:0] green, yellow, red;
  logic       walk, ped_pending;
  logic [0:0] active_way;
  logic [2:0] green3, yellow3, red3;
  logic       walk3, pend3;
  logic [1:0] aw3;
`ifdef PED_COUNTDOWN_EN
  logic [2:0] walk_remain, walk_remain3;
`endif

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  typedef struct { int kind; int way; int len; } seg_t;
  typedef struct { int lvl0; int lvl1; int g0_ticks; int g1_ticks; } vec_t;

  seg_t exp_q[$];
  vec_t vecs[5];
  int   order3[4];
  int   ord_n = 0;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(.N_WAYS(2)) dut (
    .clk(clk), .reset_n(reset_n), .ped_button(ped_button), .traffic_in(traffic_in),
    .green(green), .yellow(yellow), .red(red), .walk(walk),
    .ped_pending(ped_pending), .active_way(active_way)
`ifdef PED_COUNTDOWN_EN
    , .walk_remain(walk_remain)
`endif
  );

  traffic_phase_ctrl #(.N_WAYS(3)) dut3 (
    .clk(clk), .reset_n(reset3_n), .ped_button(1'b0), .traffic_in(9'd0),
    .green(green3), .yellow(yellow3), .red(red3), .walk(walk3),
    .ped_pending(pend3), .active_way(aw3)
`ifdef PED_COUNTDOWN_EN
    , .walk_remain(walk_remain3)
`endif
  );

  // Segment monitor: closes a segment on every lamp change and scores it.
  always @(negedge clk) begin : mon
    static int  cur_kind = 0, cur_way = 0, cur_len = 0;
    static bit  seg_valid = 1'b0;
    int   k, w;
    seg_t e;
    if (!mon_on) begin
      seg_valid = 1'b0;
    end else begin
      k = K_RED; w = 0;
      if (walk) k = K_WLK;
      else if (green != 2'b00)  begin k = K_GRN; w = green[1]  ? 1 : 0; end
      else if (yellow != 2'b00) begin k = K_YEL; w = yellow[1] ? 1 : 0; end
      if (seg_valid && k == cur_kind && w == cur_way) begin
        cur_len++;
      end else begin
        if (seg_valid && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++;
          if (e.kind != cur_kind || e.way != cur_way || e.len != cur_len) begin
            errors++;
            $display("FAIL segment: got kind %0d way %0d len %0d, want kind %0d way %0d len %0d",
                     cur_kind, cur_way, cur_len, e.kind, e.way, e.len);
          end
        end
        cur_kind = k; cur_way = w; cur_len = 1; seg_valid = 1'b1;
      end
    end
  end

  // Lamp invariants on both instances every cycle.
  always @(negedge clk) begin : inv
    int nr, bad;
    bad = 0; nr = 0;
    for (int i = 0; i < 2; i++) begin
      if (int'(green[i]) + int'(yellow[i]) + int'(red[i]) != 1) bad = 1;
      if (!red[i]) nr++;
      if ((green[i] || yellow[i]) && int'(active_way) != i) bad = 1;
    end
    if (nr > 1 || (walk && red != 2'b11)) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL lamp_inv2: g=%b y=%b r=%b walk=%b way=%0d", green, yellow, red, walk, active_way);
    end
    bad = 0; nr = 0;
    for (int i = 0; i < 3; i++) begin
      if (int'(green3[i]) + int'(yellow3[i]) + int'(red3[i]) != 1) bad = 1;
      if (!red3[i]) nr++;
    end
    if (nr > 1) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL lamp_inv3: g=%b y=%b r=%b", green3, yellow3, red3);
    end
  end

  // Order in which the 3-way instance grants green.
  always @(negedge clk) begin : ord
    static logic [2:0] prev = 3'b000;
    if (reset3_n) begin
      for (int i = 0; i < 3; i++)
        if (green3[i] && !prev[i] && ord_n < 4) begin order3[ord_n] = i; ord_n++; end
    end
    prev = green3;
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic push(input int k, input int w, input int clks);
    seg_t s;
    s.kind = k; s.way = w; s.len = clks;
    exp_q.push_back(s);
  endtask

  task automatic enter_reset();
    @(posedge clk); #1;
    mon_on  = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_on  = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin @(posedge clk); n++; end
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic press_at_e17();
    repeat (17) @(posedge clk); #1;
    ped_button = 1'b1;
  endtask

  initial begin : stim
    int n;
    int exp_ord[4];
    exp_ord = '{0, 1, 2, 0};
    vecs[0] = '{0, 0, 8, 8};
    vecs[1] = '{5, 0, 20, 8};
    vecs[2] = '{0, 7, 8, 20};
    vecs[3] = '{4, 3, 20, 8};
    vecs[4] = '{3, 4, 8, 20};

    reset_n = 1'b0; reset3_n = 1'b0; ped_button = 1'b0; traffic_in = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_red", int'(red), 3);
    chk("rst_green", int'(green), 0);
    chk("rst_yellow", int'(yellow), 0);
    chk("rst_walk", int'(walk), 0);
    chk("rst_pending", int'(ped_pending), 0);
    chk("rst_way", int'(active_way), 0);
    reset3_n = 1'b1;

    // Table: static levels, one full round of both approaches.
    for (int v = 0; v < 5; v++) begin
      enter_reset();
      traffic_in = {3'(vecs[v].lvl1), 3'(vecs[v].lvl0)};
      release_reset();
      push(K_RED, 0, 4);
      push(K_GRN, 0, vecs[v].g0_ticks * 4);
      push(K_YEL, 0, 12);
      push(K_RED, 0, 4);
      push(K_GRN, 1, vecs[v].g1_ticks * 4);
      push(K_YEL, 1, 12);
      push(K_RED, 0, 4);
      drain(600);
    end

    // Level drops below threshold while timer is 12: 13 ticks of green.
    enter_reset();
    traffic_in = {3'd0, 3'd5};
    release_reset();
    push(K_RED, 0, 4); push(K_GRN, 0, 52); push(K_YEL, 0, 12); push(K_RED, 0, 4);
    push(K_GRN, 1, 32); push(K_YEL, 1, 12); push(K_RED, 0, 4);
    repeat (53) @(posedge clk); #1;
    traffic_in = {3'd0, 3'd2};
    drain(400);

    // Short button pulse: latency, min-green cut, walk, then next approach.
    enter_reset();
    traffic_in = {3'd0, 3'd5};
    release_reset();
    push(K_RED, 0, 4); push(K_GRN, 0, 32); push(K_YEL, 0, 12); push(K_RED, 0, 4);
    push(K_WLK, 0, 24); push(K_GRN, 1, 32); push(K_YEL, 1, 12); push(K_RED, 0, 4);
    press_at_e17();
    @(posedge clk); #1;
    @(posedge clk); #1;
    ped_button = 1'b0;
    chk("ped_sync_delay", int'(ped_pending), 0);
    @(posedge clk); #1;
    chk("ped_latch", int'(ped_pending), 1);
    n = 0;
    while (walk !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
    chk("walk_seen", int'(walk), 1);
    chk("ped_clear_on_walk", int'(ped_pending), 0);
`ifdef PED_COUNTDOWN_EN
    chk("walk_remain_start", int'(walk_remain), 6);
`endif
    drain(400);

    // Button held across the walk: exactly one request.
    enter_reset();
    traffic_in = {3'd0, 3'd5};
    release_reset();
    push(K_RED, 0, 4); push(K_GRN, 0, 32); push(K_YEL, 0, 12); push(K_RED, 0, 4);
    push(K_WLK, 0, 24); push(K_GRN, 1, 32); push(K_YEL, 1, 12); push(K_RED, 0, 4);
    push(K_GRN, 0, 80);
    press_at_e17();
    repeat (200) @(posedge clk); #1;
    chk("ped_hold_single", int'(ped_pending), 0);
    ped_button = 1'b0;
    drain(300);

    // Asynchronous reset during yellow with a request pending.
    enter_reset();
    traffic_in = {3'd0, 3'd5};
    release_reset();
    push(K_RED, 0, 4); push(K_GRN, 0, 32);
    press_at_e17();
    repeat (2) @(posedge clk); #1;
    ped_button = 1'b0;
    n = 0;
    while (yellow === 2'b00 && n < 200) begin @(posedge clk); #1; n++; end
    chk("yellow_seen", int'(yellow), 1);
    drain(10);
    @(posedge clk); #3;
    chk("ped_before_rst", int'(ped_pending), 1);
    mon_on  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("arst_red", int'(red), 3);
    chk("arst_yellow", int'(yellow), 0);
    chk("arst_walk", int'(walk), 0);
    chk("arst_pending", int'(ped_pending), 0);
    traffic_in = '0;
    repeat (2) @(posedge clk);
    release_reset();
    push(K_RED, 0, 4); push(K_GRN, 0, 32); push(K_YEL, 0, 12); push(K_RED, 0, 4);
    drain(200);

    // Three-way round robin order.
    n = 0;
    while (ord_n < 4 && n < 1000) begin @(posedge clk); n++; end
    chk("order3_count", ord_n, 4);
    for (int i = 0; i < 4; i++)
      if (i < ord_n) chk($sformatf("order3_%0d", i), order3[i], exp_ord[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
